mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_pkg.sv | 29 ++
 rtl/mux_scan_ctrl_if.sv | 36 +++
 rtl/mux_scan_next.sv | 31 +++
 rtl/mux_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mux_scan_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/mux_scan_pkg.sv
// -----------------------------------------------------------------------------
// mux_scan_pkg
// Shared sizes, FSM state encoding and a channel-search helper for the
// multiplexed scan controller.
// No ports (package).
// -----------------------------------------------------------------------------
package mux_scan_pkg;

   localparam int unsigned N_CH  = 4;   // mux inputs scanned
   localparam int unsigned SEL_W = 2;   // width of the mux select
   localparam int unsigned CNT_W = 4;   // settle counter width (SETTLE <= 15)

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_STALL  = 2'd2
   } state_t;

   // Lowest set bit of a channel mask; 0 when the mask is empty.
   function automatic logic [SEL_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if (m[i]) r = SEL_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl_if
// Groups the control, mux and result-handshake signals of mux_scan_ctrl.
//   start, cont     : scan request / continuous mode
//   en_mask         : per-channel enable
//   mux_in          : output of the external 4:1 mux
//   sel             : select driven to the external mux
//   word/word_valid : scan result, held until word_ready
//   word_ready      : consumer accept
//   busy            : controller not idle
// Modports: master (environment side), slave (controller side).
// -----------------------------------------------------------------------------
interface mux_scan_ctrl_if;
   import mux_scan_pkg::*;

   logic              start;
   logic              cont;
   logic [N_CH-1:0]   en_mask;
   logic              mux_in;
   logic [SEL_W-1:0]  sel;
   logic [N_CH-1:0]   word;
   logic              word_valid;
   logic              word_ready;
   logic              busy;

   modport master (
      output start, cont, en_mask, mux_in, word_ready,
      input  sel, word, word_valid, busy
   );

   modport slave (
      input  start, cont, en_mask, mux_in, word_ready,
      output sel, word, word_valid, busy
   );

endinterface

// File: rtl/mux_scan_next.sv
// -----------------------------------------------------------------------------
// mux_scan_next
// Combinational channel sequencer: finds the next enabled channel above the
// current select and flags when the current select is the last one enabled.
//   mask       in  : latched channel mask
//   cur        in  : current select
//   next_sel_c out : next higher enabled channel (cur when none)
//   last_c     out : no enabled channel above cur
// -----------------------------------------------------------------------------
module mux_scan_next
   import mux_scan_pkg::*;
(
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] next_sel_c,
   output logic             last_c
);

   // Walk downward so the lowest qualifying channel is the one that sticks.
   always_comb begin
      next_sel_c = cur;
      last_c     = 1'b1;
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         if ((i > int'(cur)) && mask[i]) begin
            next_sel_c = SEL_W'(i);
            last_c     = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// mux_scan_ctrl
// Steps an external 4:1 mux through the enabled channels, holds each select
// for SETTLE cycles, samples the mux output on the last settle cycle and
// assembles the samples into a word with a valid/ready handshake.
//   SETTLE   param : cycles each select is held before sampling (1..15)
//   clk      in    : clock, rising edge
//   rst      in    : synchronous active-high reset
//   bus      slave : start/cont/en_mask/mux_in/word_ready in,
//                    sel/word/word_valid/busy out (all registered)
// -----------------------------------------------------------------------------
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   mux_scan_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

   state_t             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N_CH-1:0]    mask_q, mask_d;
   logic [N_CH-1:0]    shadow_q, shadow_d;
   logic [N_CH-1:0]    word_q, word_d;
   logic               word_valid_q, word_valid_d;
   logic               busy_q, busy_d;

   logic [SEL_W-1:0]   next_sel_c;
   logic               last_c;
   logic [N_CH-1:0]    captured_c;
   logic [N_CH-1:0]    load_val_c;
   logic               do_load_c;
   logic               can_load_c;

   mux_scan_next u_next (
      .mask       (mask_q),
      .cur        (sel_q),
      .next_sel_c (next_sel_c),
      .last_c     (last_c)
   );

   // Shadow word with the channel currently on sel replaced by the mux output.
   always_comb begin
      captured_c         = shadow_q;
      captured_c[sel_q]  = bus.mux_in;
   end

   assign can_load_c = !word_valid_q || bus.word_ready;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sel_q        <= '0;
         cnt_q        <= '0;
         mask_q       <= '0;
         shadow_q     <= '0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         mask_q       <= mask_d;
         shadow_q     <= shadow_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      mask_d       = mask_q;
      shadow_d     = shadow_q;
      word_d       = word_q;
      word_valid_d = word_valid_q;
      do_load_c    = 1'b0;
      load_val_c   = shadow_q;

      // Consumer handshake; a word load below takes precedence.
      if (word_valid_q && bus.word_ready) word_valid_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            sel_d = '0;
            if (bus.start && (bus.en_mask != '0)) begin
               mask_d   = bus.en_mask;
               shadow_d = '0;
               sel_d    = lowest_ch(bus.en_mask);
               cnt_d    = SETTLE_CNT;
               state_d  = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (cnt_q == CNT_W'(1)) begin
               shadow_d = captured_c;
               if (last_c) begin
                  if (can_load_c) begin
                     do_load_c  = 1'b1;
                     load_val_c = captured_c;
                  end else begin
                     state_d = ST_STALL;
                  end
               end else begin
                  sel_d = next_sel_c;
                  cnt_d = SETTLE_CNT;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_STALL: begin
            if (bus.word_ready) begin
               do_load_c  = 1'b1;
               load_val_c = shadow_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
         end
      endcase

      // Publishing a word either restarts (continuous mode) or returns to idle.
      if (do_load_c) begin
         word_d       = load_val_c;
         word_valid_d = 1'b1;
         if (bus.cont && (bus.en_mask != '0)) begin
            mask_d   = bus.en_mask;
            shadow_d = '0;
            sel_d    = lowest_ch(bus.en_mask);
            cnt_d    = SETTLE_CNT;
            state_d  = ST_SETTLE;
         end else begin
            sel_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign bus.sel        = sel_q;
   assign bus.word       = word_q;
   assign bus.word_valid = word_valid_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_ctrl
// Drives two controllers (SETTLE=1 and SETTLE=3) from shared stimulus, each
// closing its loop through a behavioural 4:1 mux, and checks them against
// expectations derived from the enabled-channel list and settle time.
// -----------------------------------------------------------------------------
module tb_mux_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       cont = 1'b0;
   logic       word_ready = 1'b1;
   logic [3:0] en_mask = 4'b0000;
   logic [3:0] chan_in = 4'b0000;

   int         vectors = 0;
   int         miscompares = 0;
   logic [3:0] exp_word [2];

   always #5 clk = ~clk;

   mux_scan_ctrl_if if1 ();
   mux_scan_ctrl_if if3 ();

   assign if1.start      = start;
   assign if1.cont       = cont;
   assign if1.en_mask    = en_mask;
   assign if1.word_ready = word_ready;
   assign if3.start      = start;
   assign if3.cont       = cont;
   assign if3.en_mask    = en_mask;
   assign if3.word_ready = word_ready;

   // Behavioural 4:1 mux per controller.
   assign if1.mux_in = chan_in[if1.sel];
   assign if3.mux_in = chan_in[if3.sel];

   mux_scan_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   mux_scan_ctrl #(.SETTLE(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

   function automatic logic [1:0] get_sel(input int k);
      return (k == 0) ? if1.sel : if3.sel;
   endfunction
   function automatic logic [3:0] get_word(input int k);
      return (k == 0) ? if1.word : if3.word;
   endfunction
   function automatic logic get_valid(input int k);
      return (k == 0) ? if1.word_valid : if3.word_valid;
   endfunction
   function automatic logic get_busy(input int k);
      return (k == 0) ? if1.busy : if3.busy;
   endfunction

   task automatic chk(input string tag, input int k, input logic [7:0] obs,
                      input logic [7:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int k, input logic [1:0] s,
                          input logic [3:0] w, input logic v, input logic b);
      chk({tag, ".sel"},   k, 8'(get_sel(k)),   8'(s));
      chk({tag, ".word"},  k, 8'(get_word(k)),  8'(w));
      chk({tag, ".valid"}, k, 8'(get_valid(k)), 8'(v));
      chk({tag, ".busy"},  k, 8'(get_busy(k)),  8'(b));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      start = 1'b0;
      cont = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      exp_word[0] = 4'b0000;
      exp_word[1] = 4'b0000;
   endtask

   // One non-continuous scan with ready held high; expectations come from the
   // ascending list of enabled channels and each controller's settle time.
   task automatic run_scan(input logic [3:0] m, input logic [3:0] din,
                           input bit hold);
      int chs[$];
      int n;
      int s;
      logic [3:0] res;
      for (int i = 0; i < 4; i++) if (m[i]) chs.push_back(i);
      n   = chs.size();
      res = din & m;
      @(negedge clk);
      en_mask    = m;
      chan_in    = din;
      start      = 1'b1;
      cont       = 1'b0;
      word_ready = 1'b1;
      for (int t = 0; t <= 13; t++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            s = (k == 0) ? 1 : 3;
            if (t < n * s)
               chk_all("scan", k, 2'(chs[t / s]), exp_word[k], 1'b0, 1'b1);
            else
               chk_all("done", k, 2'b00, res, (t == n * s), 1'b0);
         end
         // Start held through the first controller's scan must be ignored.
         start = (hold && (t + 1 <= n - 1)) ? 1'b1 : 1'b0;
         if (t == 0) en_mask = 4'($urandom);
      end
      exp_word[0] = res;
      exp_word[1] = res;
   endtask

   initial begin
      logic [3:0] m;
      exp_word[0] = 4'b0000;
      exp_word[1] = 4'b0000;

      // Reset state.
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk_all("reset", k, 2'b00, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;

      // Full mask, SETTLE=1 sequence 0,1,2,3 with start held mid-scan.
      run_scan(4'b1111, 4'b0110, 1'b1);
      // Sparse mask: SETTLE=3 holds sel 1 then 3 for three cycles each.
      run_scan(4'b1010, 4'b1111, 1'b0);

      // Empty mask start is ignored.
      @(negedge clk);
      en_mask = 4'b0000;
      start   = 1'b1;
      repeat (3) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("mask0.busy",  k, 8'(get_busy(k)),  8'd0);
            chk("mask0.valid", k, 8'(get_valid(k)), 8'd0);
         end
      end
      start = 1'b0;

      // Continuous mode with a stalled consumer (SETTLE=1 controller).
      do_reset();
      en_mask = 4'b0001; cont = 1'b1; word_ready = 1'b0; chan_in = 4'b0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk_all("cont.e0", 0, 2'd0, 4'b0000, 1'b0, 1'b1);
      @(negedge clk);
      chk_all("cont.e1", 0, 2'd0, 4'b0001, 1'b1, 1'b1);
      chan_in = 4'b0000;
      @(negedge clk);
      chk_all("stall.e2", 0, 2'd0, 4'b0001, 1'b1, 1'b1);
      @(negedge clk);
      chk_all("stall.e3", 0, 2'd0, 4'b0001, 1'b1, 1'b1);
      word_ready = 1'b1; cont = 1'b0;
      @(negedge clk);
      chk_all("stall.load", 0, 2'd0, 4'b0000, 1'b1, 1'b0);
      word_ready = 1'b0;
      @(negedge clk);
      chk("hold.valid", 0, 8'(get_valid(0)), 8'd1);
      word_ready = 1'b1;
      @(negedge clk);
      chk("drain.valid", 0, 8'(get_valid(0)), 8'd0);

      // Mask change mid-scan only affects the following continuous scan.
      do_reset();
      en_mask = 4'b1111; cont = 1'b1; word_ready = 1'b1; chan_in = 4'b1011;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; en_mask = 4'b0001;
      repeat (3) @(negedge clk);
      chk_all("remask.e3", 0, 2'd3, 4'b0000, 1'b0, 1'b1);
      @(negedge clk);
      chk_all("remask.e4", 0, 2'd0, 4'b1011, 1'b1, 1'b1);
      cont = 1'b0;
      @(negedge clk);
      chk_all("remask.e5", 0, 2'd0, 4'b0001, 1'b1, 1'b0);

      // Reset in the middle of a scan, then a clean scan.
      do_reset();
      en_mask = 4'b1111; chan_in = 4'b1111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midrst.sel2", 0, 8'(get_sel(0)), 8'd2);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) chk_all("midrst", k, 2'd0, 4'b0000, 1'b0, 1'b0);
      rst = 1'b0;
      run_scan(4'b1111, 4'($urandom), 1'b0);

      // Randomized single scans.
      for (int r = 0; r < 20; r++) begin
         m = 4'($urandom_range(1, 15));
         run_scan(m, 4'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
